// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// Holds the controller state encoding and the counter width helper.
package mult_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_FIN  = 2'b10
   } state_e;

   function automatic int cnt_w(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/mult_abs_neg.sv
// Combinational conditional two's-complement negate.
// Serves both as operand magnitude unit and result sign fix.
module mult_abs_neg #(
   parameter int W = 8
) (
   input  logic [W-1:0] x,
   input  logic         neg,
   output logic [W-1:0] y
);

   assign y = neg ? (W'(0) - x) : x;

endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential shift-add multiplier with start/busy/done handshake,
// optional signed mode and early exit on an exhausted multiplier.
module seq_shift_add_mult
   import mult_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int CNT_W = cnt_w(WIDTH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               signed_en,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [CNT_W-1:0]   count_out,
   output logic [2*WIDTH-1:0] product
);

   localparam int PW = 2 * WIDTH;

   state_e           state_q, state_d;
   logic [PW-1:0]    acc_q, acc_d;
   logic [PW-1:0]    mcand_q, mcand_d;
   logic [WIDTH-1:0] mb_q, mb_d;
   logic             neg_q, neg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PW-1:0]    prod_q, prod_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;

   logic [WIDTH-1:0] mag_a, mag_b;
   logic [PW-1:0]    acc_fix;
   logic [WIDTH-1:0] mb_shift;

   mult_abs_neg #(.W(WIDTH)) u_abs_a (
      .x   (a),
      .neg (signed_en & a[WIDTH-1]),
      .y   (mag_a)
   );

   mult_abs_neg #(.W(WIDTH)) u_abs_b (
      .x   (b),
      .neg (signed_en & b[WIDTH-1]),
      .y   (mag_b)
   );

   mult_abs_neg #(.W(PW)) u_fix (
      .x   (acc_q),
      .neg (neg_q),
      .y   (acc_fix)
   );

   assign mb_shift = mb_q >> 1;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      mcand_d = mcand_q;
      mb_d    = mb_q;
      neg_d   = neg_q;
      cnt_d   = cnt_q;
      prod_d  = prod_q;
      done_d  = 1'b0;
      busy_d  = busy_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               acc_d   = '0;
               mcand_d = {{WIDTH{1'b0}}, mag_a};
               mb_d    = mag_b;
               neg_d   = signed_en & (a[WIDTH-1] ^ b[WIDTH-1]);
               cnt_d   = CNT_W'(WIDTH);
               busy_d  = 1'b1;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (mb_q[0]) acc_d = acc_q + mcand_q;
            mcand_d = mcand_q << 1;
            mb_d    = mb_shift;
            cnt_d   = cnt_q - 1'b1;
            // Leave as soon as no set multiplier bits remain
            if (cnt_q == CNT_W'(1) || mb_shift == '0)
               state_d = S_FIN;
         end
         S_FIN: begin
            prod_d  = acc_fix;
            done_d  = 1'b1;
            cnt_d   = '0;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         mcand_q <= '0;
         mb_q    <= '0;
         neg_q   <= 1'b0;
         cnt_q   <= '0;
         prod_q  <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         mb_q    <= mb_d;
         neg_q   <= neg_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign count_out = cnt_q;
   assign product   = prod_q;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Self-checking bench for seq_shift_add_mult (WIDTH=8):
// directed cases plus random operands against an arithmetic model.
module tb_seq_shift_add_mult;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        signed_en;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        busy;
   logic        done;
   logic [3:0]  count_out;
   logic [15:0] product;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [15:0] exp_prev = 16'h0;

   seq_shift_add_mult #(.WIDTH(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .signed_en (signed_en),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .count_out (count_out),
      .product   (product)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] model_prod(input logic [7:0] ta,
                                              input logic [7:0] tb,
                                              input logic ts);
      int sa, sb;
      sa = ts ? int'($signed(ta)) : int'(ta);
      sb = ts ? int'($signed(tb)) : int'(tb);
      return 16'(sa * sb);
   endfunction

   function automatic int model_runs(input logic [7:0] tb,
                                     input logic ts);
      int mb, n;
      mb = ts ? int'($signed(tb)) : int'(tb);
      if (mb < 0) mb = -mb;
      n = 1;
      for (int i = 0; i < 9; i++)
         if (((mb >> i) & 1) == 1) n = i + 1;
      return n;
   endfunction

   // Drive start at the current negedge; return at the negedge after E0.
   task automatic launch(input logic [7:0] ta, input logic [7:0] tb,
                         input logic ts);
      start = 1'b1;
      a = ta;
      b = tb;
      signed_en = ts;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", busy, 1);
      check("done_not_held", done, 0);
   endtask

   task automatic wait_done(input string tag, input int n,
                            input logic [15:0] ep, input int inj);
      int k;
      k = 0;
      while (done !== 1'b1 && k <= 40) begin
         if (k <= n) check({tag, "_cnt"}, count_out, 8 - k);
         check({tag, "_hold"}, product, exp_prev);
         check({tag, "_busy"}, busy, 1);
         if (k == inj) begin
            start = 1'b1;
            a = 8'($urandom);
            b = 8'($urandom);
            signed_en = 1'($urandom);
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         k++;
      end
      start = 1'b0;
      check({tag, "_latency"}, k, n + 1);
      check({tag, "_prod"}, product, ep);
      check({tag, "_busy_done"}, busy, 0);
      check({tag, "_cnt_done"}, count_out, 0);
      exp_prev = ep;
   endtask

   task automatic run_op(input string tag, input logic [7:0] ta,
                         input logic [7:0] tb, input logic ts,
                         input logic [15:0] ep, input int n);
      launch(ta, tb, ts);
      wait_done(tag, n, ep, -1);
      @(negedge clk);
      check({tag, "_pulse"}, done, 0);
   endtask

   initial begin
      logic [7:0]  ra, rb;
      logic        rs;
      reset = 1'b1;
      start = 1'b0;
      signed_en = 1'b0;
      a = 8'h0;
      b = 8'h0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_cnt", count_out, 0);
      check("rst_prod", product, 0);
      @(negedge clk);

      run_op("u13x11", 8'd13, 8'd11, 1'b0, 16'h008F, 4);
      run_op("u255x255", 8'd255, 8'd255, 1'b0, 16'hFE01, 8);
      run_op("b0", 8'd200, 8'd0, 1'b0, 16'h0000, 1);
      run_op("b1", 8'd7, 8'd1, 1'b0, 16'h0007, 1);
      run_op("sm3x5", 8'hFD, 8'd5, 1'b1, 16'hFFF1, 3);
      run_op("sm128", 8'h80, 8'h80, 1'b1, 16'h4000, 8);
      run_op("s0xm1", 8'h00, 8'hFF, 1'b1, 16'h0000, 1);

      launch(8'd255, 8'd255, 1'b0);
      wait_done("ignore", 8, 16'hFE01, 2);
      launch(8'd6, 8'd7, 1'b0);
      wait_done("b2b", 3, 16'd42, -1);
      @(negedge clk);

      launch(8'd255, 8'd255, 1'b0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_prod", product, 0);
      check("abort_cnt", count_out, 0);
      exp_prev = 16'h0;
      for (int i = 0; i < 12; i++) begin
         check("abort_no_done", done, 0);
         @(negedge clk);
      end
      run_op("after_rst", 8'd6, 8'd7, 1'b0, 16'd42, 3);

      for (int i = 0; i < 30; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rs = 1'($urandom);
         if (i % 5 == 0) rb = rb >> (i % 8);
         run_op("rand", ra, rb, rs, model_prod(ra, rb, rs),
                model_runs(rb, rs));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/seq_shift_add_mult.md
Name: seq_shift_add_mult

Overview:
Parametrised sequential shift-add multiplier. It generalises the fixed 3-bit multiplier FSM to any WIDTH. It adds a start/busy/done handshake, an optional signed (two's-complement) mode, and early termination once the remaining multiplier bits are zero. It sits beside the other arithmetic FSMs as a low-area multiplier driven by a controller.

Parameters:
WIDTH, 8, operand width in bits (min 2); product is 2*WIDTH bits
CNT_W, $clog2(WIDTH+1), width of the remaining-bit counter (derived, not overridden)

Ports:
clk  input  1  single clock, all logic on posedge
reset  input  1  synchronous, active-high
start  input  1  request; accepted only when busy=0
signed_en  input  1  1 = operands two's-complement; sampled with start
a  input  WIDTH  multiplicand; sampled with start
b  input  WIDTH  multiplier; sampled with start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when product is updated
count_out  output  CNT_W  remaining multiplier bits to process
product  output  2*WIDTH  result; holds until the next done

Behaviour:
- Reset (synchronous, active-high) forces state IDLE, busy=0, done=0, count_out=0, product=0, and clears all internal registers. Reset applies in any state and mid-operation; the aborted operation produces no done.
- States: IDLE, RUN, FIN (encoded 2'b00, 2'b01, 2'b10). 2'b11 is illegal and returns to IDLE.
- IDLE: when start=1 at edge E0:
  - latch mag_a=|a| and mag_b=|b| (|x| only when signed_en=1; otherwise raw);
  - latch neg = signed_en & (a[W-1]^b[W-1]);
  - set acc=0, mcand={W'b0,mag_a}, count_out=WIDTH;
  - go to RUN.
- RUN, each edge:
  - if mag_b[0], acc += mcand (2W-bit add, no overflow possible);
  - mcand <<= 1, mag_b >>= 1, count_out -= 1.
  - Go to FIN when count_out reaches 0 or the shifted mag_b == 0 (early termination). RUN always executes at least one cycle.
- FIN, one edge:
  - product <= neg ? -acc : acc (2W-bit two's complement);
  - done <= 1, count_out <= 0;
  - go to IDLE.
- RUN cycle count n = max(1, position of highest set bit of mag_b + 1). done is visible after edge E(n+1).
- busy is registered: 1 from after E0 through the FIN edge, 0 in the done cycle.
- start while busy=1 is ignored; operands are not re-sampled.
- Back-to-back: start during the done cycle (state IDLE) is accepted; product keeps the previous value until the next FIN.
- Signed corner case: |-2^(W-1)| = 2^(W-1) fits in W unsigned bits. For W=8, -128*-128 = 16384 fits in 16-bit signed. A zero product is never negated to a non-zero value.
- signed_en=0 with a top bit set means a plain unsigned operand.
- done is a single-cycle pulse, never held.

Decomposition:
- Shared package mult_pkg: state enum/localparams (S_IDLE, S_RUN, S_FIN), clog2-based CNT_W helper.
- One sub-module is natural: mult_abs_neg, a combinational parametrised magnitude/conditional-negate unit. It is instantiated twice at WIDTH (operand magnitudes) and once at 2*WIDTH (result sign fix).
- Controller FSM and datapath registers stay in seq_shift_add_mult.

Test Plan:
1. WIDTH=8, unsigned, a=13, b=11 -> 4 RUN cycles; count_out 8,7,6,5; done after edge 5; product=0x008F (143); busy low in done cycle.
2. unsigned, a=255, b=255 -> 8 RUN cycles, done after edge 9, product=0xFE01.
3. b=0, a=200 -> 1 RUN cycle (early exit), done after edge 2, product=0x0000. Also b=1, a=7 -> done after edge 2, product=7.
4. Signed cases:
   - a=-3 (0xFD), b=5 -> product=0xFFF1;
   - a=-128, b=-128 -> product=0x4000;
   - a=0, b=-1 -> product=0x0000.
5. start pulsed mid-RUN with other operands -> ignored, original result produced. A second start in the done cycle is accepted; product holds the old value until its own done.
6. reset asserted in the 3rd RUN cycle of 255*255 -> next cycle busy=0, done=0, product=0, count_out=0, no done pulse. A following op 6*7 -> product=42.
